// File: rtl/decoder_scan_seq.sv
// Active-low one-hot decoder that can either decode SEL directly or scan its outputs.
// In scan mode each output dwells DWELL+1 cycles, with an optional all-high guard cycle between steps.
module decoder_scan_seq #(
    parameter int SEL_W   = 2,
    parameter int LAST    = (1 << SEL_W) - 1,
    parameter int DWELL_W = 8,
    parameter int GUARD   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    G,
    input  logic                    MODE,
    input  logic [SEL_W-1:0]        SEL,
    input  logic [DWELL_W-1:0]      DWELL,
    output logic [(1<<SEL_W)-1:0]   Y,
    output logic [SEL_W-1:0]        IDX,
    output logic                    WRAP,
    output logic [1:0]              dbg_state
);

    localparam int NOUT = 1 << SEL_W;
    localparam logic [SEL_W:0]   LAST_X = (SEL_W+1)'(LAST);
    localparam logic [SEL_W-1:0] LAST_I = SEL_W'(LAST);
    localparam logic [NOUT-1:0]  ONES   = '1;

    typedef enum logic [1:0] {
        STATIC     = 2'd0,
        SCAN_ON    = 2'd1,
        SCAN_GUARD = 2'd2
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic               sel_ok;
    logic [SEL_W-1:0]   start_idx;
    logic [SEL_W-1:0]   next_idx;
    logic [NOUT-1:0]    static_y;

    function automatic logic [NOUT-1:0] dec(input logic [SEL_W-1:0] i);
        dec = ~(NOUT'(1) << i);
    endfunction

    always_comb begin
        sel_ok    = ({1'b0, SEL} <= LAST_X);
        start_idx = sel_ok ? SEL : '0;
        next_idx  = (IDX == LAST_I) ? '0 : IDX + SEL_W'(1);
        static_y  = (!G && sel_ok) ? dec(SEL) : ONES;
    end

    assign dbg_state = state;

    // Scan-state priority: MODE=0 exits, then G=1 freezes, then guard exit, step, or count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= STATIC;
            Y     <= ONES;
            IDX   <= '0;
            WRAP  <= 1'b0;
            cnt   <= '0;
        end else begin
            WRAP <= 1'b0;
            case (state)
                STATIC: begin
                    cnt <= '0;
                    if (MODE) begin
                        state <= SCAN_ON;
                        IDX   <= start_idx;
                        Y     <= G ? ONES : dec(start_idx);
                    end else begin
                        IDX <= SEL;
                        Y   <= static_y;
                    end
                end
                SCAN_ON, SCAN_GUARD: begin
                    if (!MODE) begin
                        state <= STATIC;
                        IDX   <= SEL;
                        cnt   <= '0;
                        Y     <= static_y;
                    end else if (G) begin
                        Y <= ONES;
                    end else if (state == SCAN_GUARD) begin
                        state <= SCAN_ON;
                        Y     <= dec(IDX);
                    end else if (cnt >= DWELL) begin
                        // >= so a DWELL lowered below the running count steps at once
                        cnt  <= '0;
                        IDX  <= next_idx;
                        WRAP <= (IDX == LAST_I);
                        if (GUARD != 0) begin
                            state <= SCAN_GUARD;
                            Y     <= ONES;
                        end else begin
                            Y <= dec(next_idx);
                        end
                    end else begin
                        cnt <= cnt + DWELL_W'(1);
                        Y   <= dec(IDX);
                    end
                end
                default: begin
                    state <= STATIC;
                    Y     <= ONES;
                end
            endcase
        end
    end

endmodule

// File: doc/decoder_scan_seq.md
DECODER_SCAN_SEQ -- requirements
Module: decoder_scan_seq

Interface
REQ-001 Parameter SEL_W, default 2: select width; output count NOUT = 2**SEL_W.
REQ-002 Parameter LAST, default NOUT-1: highest index visited in scan mode; legal range 0..NOUT-1.
REQ-003 Parameter DWELL_W, default 8: width of the dwell-length input.
REQ-004 Parameter GUARD, default 1: 1 inserts one all-high guard cycle between scan steps; 0 omits it.
REQ-005 CLK  input  1  system clock; all state changes on its rising edge.
REQ-006 RST  input  1  reset; asynchronous and active-high.
REQ-007 G  input  1  active-low enable; 1 forces all outputs high.
REQ-008 MODE  input  1  0 = static decode of SEL; 1 = auto-scan.
REQ-009 SEL  input  SEL_W  static select index; also the scan start index.
REQ-010 DWELL  input  DWELL_W  scan step length minus one, in cycles.
REQ-011 Y  output  NOUT  registered active-low one-hot decode; bit i low selects output i.
REQ-012 IDX  output  SEL_W  index currently driven, or about to be driven during a guard cycle.
REQ-013 WRAP  output  1  one-cycle high pulse when scan advances from LAST to 0.

Function
REQ-014 The FSM SHALL have the states STATIC, SCAN_ON and SCAN_GUARD; reset state is STATIC.
REQ-015 STATIC: each cycle IDX <= SEL, dwell counter <= 0, and Y <= ~(1<<SEL) if G=0 and SEL<=LAST, otherwise all ones; latency from input to Y is one cycle.
REQ-016 STATIC -> SCAN_ON when MODE=1 is sampled; the scan starts at IDX = current SEL, or at 0 if SEL>LAST.
REQ-017 SCAN_ON: Y = ~(1<<IDX) while G=0; the dwell counter increments each cycle with G=0.
REQ-018 Step: when dwell counter == DWELL in SCAN_ON, the counter SHALL clear and IDX SHALL advance to IDX+1, or to 0 if IDX==LAST.
REQ-019 With GUARD=1 a step SHALL go SCAN_ON -> SCAN_GUARD for exactly one cycle with Y all ones and IDX already advanced, then return to SCAN_ON.
REQ-020 With GUARD=0 a step SHALL stay in SCAN_ON, and Y SHALL move directly to the new index on the next cycle.
REQ-021 Each output is therefore low for DWELL+1 cycles per step; a full period is (LAST+1)*(DWELL+1+GUARD) cycles.
REQ-022 DWELL=0 SHALL step every cycle with GUARD=0, and every two cycles with GUARD=1.
REQ-023 WRAP SHALL be high for exactly the one cycle in which IDX takes the value 0 from LAST, and low at all other times.
REQ-024 G=1 in SCAN_ON or SCAN_GUARD SHALL freeze IDX, the dwell counter and the state, and force Y all ones; on G=0 the scan resumes with the remaining dwell.
REQ-025 MODE=0 sampled in either scan state SHALL return the FSM to STATIC in one cycle, with any pending guard cycle abandoned.
REQ-026 DWELL changing mid-step SHALL take effect at the next compare; if the counter already exceeds the new DWELL, the step SHALL occur on the next cycle.
REQ-027 If G=1 and MODE=0 in the same cycle, G SHALL take priority: Y is all ones and the FSM goes to STATIC.
REQ-028 Y SHALL never have more than one bit low in any cycle.

Reset
REQ-029 While RST=1: state = STATIC, Y = all ones, IDX = 0, WRAP = 0, dwell counter = 0, regardless of CLK.
REQ-030 RST asserted mid-scan SHALL clear all state immediately; after release, the first edge behaves as STATIC.

Verification
REQ-031 SEL_W=2, MODE=0, G=0, SEL=2 -> Y=4'b1011 one cycle later; then G=1 -> Y=4'b1111 on the next cycle.
REQ-032 SEL_W=2, LAST=2, MODE=0, SEL=3, G=0 -> Y=4'b1111 (index outside LAST).
REQ-033 GUARD=1, DWELL=2, SEL=0, MODE rises -> 1110 x3 cycles, 1111 x1, 1101 x3, 1111 x1, 1011 x3, 1111 x1, 0111 x3, 1111 x1 with WRAP high, then 1110.
REQ-034 GUARD=0, DWELL=0 -> Y rotates 1110, 1101, 1011, 0111 on consecutive cycles; WRAP pulses once every 4 cycles.
REQ-035 Mid-step G=1 for 5 cycles -> Y all ones, IDX unchanged; after G=0 the same output completes only its remaining dwell cycles.
REQ-036 RST pulse between clock edges during a scan -> Y=1111, IDX=0, WRAP=0 immediately; after release with MODE=0, SEL=1, G=0 -> Y=1101 after one edge.
